// File: rtl/rgmii_rx.sv
// RGMII receive decoder: rebuilds bytes from IDDR rise/fall samples at
// 10/100/1000 Mbps, frames them onto an AXIS master with tlast/tuser,
// decodes in-band link status and keeps saturating frame/error counters.
module rgmii_rx #(
   parameter bit STRIP_PREAMBLE = 1'b0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk_rx,
   input  logic                 reset,
   input  logic [3:0]           rxd_rise,
   input  logic [3:0]           rxd_fall,
   input  logic                 rx_ctl_rise,
   input  logic                 rx_ctl_fall,
   input  logic [1:0]           phy_speed_status,
   output logic [7:0]           rx_axis_rgmii_tdata,
   output logic                 rx_axis_rgmii_tvalid,
   output logic                 rx_axis_rgmii_tlast,
   output logic                 rx_axis_rgmii_tuser,
   output logic                 inband_link_status,
   output logic [1:0]           inband_speed_status,
   output logic                 inband_duplex,
   output logic [CNT_WIDTH-1:0] rx_frame_cnt,
   output logic [CNT_WIDTH-1:0] rx_error_cnt
);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;

   state_t       state, state_n, eff_state;
   logic [1:0]   spd_meta, spd, spd_d;
   logic         dv_prev;
   logic         nib_phase, nib_phase_n;
   logic [3:0]   nib_low;
   logic         hold_valid, hold_valid_n;
   logic [7:0]   hold_data, hold_data_n;
   logic         frame_bad, frame_bad_n;
   logic         fc_prev;

   logic         dv, er, gig, spd_chg;
   logic         byte_vld;
   logic [7:0]   byte_data;
   logic         emit, emit_last, emit_user;
   logic         frame_err, final_bad;
   logic         fc_cond, fc_event;
   logic [1:0]   err_inc;
   logic [CNT_WIDTH:0] frame_sum, err_sum;

   assign dv       = rx_ctl_rise;
   assign er       = rx_ctl_rise ^ rx_ctl_fall;
   assign gig      = spd[1];
   assign spd_chg  = (spd != spd_d);
   assign fc_cond  = !dv && er && (rxd_rise == 4'hE);
   assign fc_event = fc_cond && !fc_prev;

   // Byte assembly: whole byte per cycle at 1000, low-then-high nibble otherwise.
   always_comb begin
      byte_vld    = 1'b0;
      byte_data   = {rxd_fall, rxd_rise};
      nib_phase_n = 1'b0;
      if (dv) begin
         if (gig) begin
            byte_vld = 1'b1;
         end else begin
            byte_vld    = nib_phase;
            byte_data   = {rxd_rise, nib_low};
            nib_phase_n = ~nib_phase;
         end
      end
   end

   // Next-state, hold-register and emit decisions for the framing FSM.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_n      = state;
      hold_valid_n = hold_valid;
      hold_data_n  = hold_data;
      frame_bad_n  = frame_bad;
      emit         = 1'b0;
      emit_last    = 1'b0;
      emit_user    = 1'b0;
      frame_err    = 1'b0;
      final_bad    = frame_bad | nib_phase;

      // A carrier still high from before reset is ignored until it drops.
      eff_state = state;
      if (state == IDLE && dv) begin
         if (dv_prev)             eff_state = DROP;
         else if (STRIP_PREAMBLE) eff_state = PREAMBLE;
         else                     eff_state = DATA;
      end

      case (eff_state)
         PREAMBLE: begin
            state_n = PREAMBLE;
            if (!dv) begin
               frame_err = 1'b1;
               state_n   = IDLE;
            end else if (er || spd_chg) begin
               frame_err = 1'b1;
               state_n   = DROP;
            end else if (byte_vld) begin
               if (byte_data == SFD_BYTE) begin
                  state_n = DATA;
               end else if (byte_data != PRE_BYTE) begin
                  frame_err = 1'b1;
                  state_n   = DROP;
               end
            end
         end
         DATA: begin
            state_n = DATA;
            if (dv && spd_chg) begin
               // Rate changed under the frame: close it as bad right away.
               emit         = hold_valid;
               emit_last    = 1'b1;
               emit_user    = 1'b1;
               frame_err    = 1'b1;
               hold_valid_n = 1'b0;
               frame_bad_n  = 1'b0;
               state_n      = DROP;
            end else if (dv) begin
               if (er) frame_bad_n = 1'b1;
               if (byte_vld) begin
                  emit         = hold_valid;
                  hold_valid_n = 1'b1;
                  hold_data_n  = byte_data;
               end
            end else begin
               // End of carrier: the held byte is the last one; a dangling
               // nibble marks the frame bad and is discarded.
               emit         = hold_valid;
               emit_last    = 1'b1;
               emit_user    = final_bad;
               frame_err    = final_bad;
               hold_valid_n = 1'b0;
               frame_bad_n  = 1'b0;
               state_n      = IDLE;
            end
         end
         DROP: begin
            hold_valid_n = 1'b0;
            frame_bad_n  = 1'b0;
            state_n      = dv ? DROP : IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      err_inc   = {1'b0, frame_err} + {1'b0, fc_event};
      frame_sum = {1'b0, rx_frame_cnt} + {{CNT_WIDTH{1'b0}}, (emit & emit_last)};
      err_sum   = {1'b0, rx_error_cnt} + {{(CNT_WIDTH-1){1'b0}}, err_inc};
   end

   // State, synchronizer, output and counter registers.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_rx) begin
      if (reset) begin
         state                <= IDLE;
         spd_meta             <= 2'd0;
         spd                  <= 2'd0;
         spd_d                <= 2'd0;
         dv_prev              <= 1'b1;
         nib_phase            <= 1'b0;
         nib_low              <= 4'd0;
         hold_valid           <= 1'b0;
         hold_data            <= 8'd0;
         frame_bad            <= 1'b0;
         fc_prev              <= 1'b0;
         rx_axis_rgmii_tdata  <= 8'd0;
         rx_axis_rgmii_tvalid <= 1'b0;
         rx_axis_rgmii_tlast  <= 1'b0;
         rx_axis_rgmii_tuser  <= 1'b0;
         inband_link_status   <= 1'b0;
         inband_speed_status  <= 2'd0;
         inband_duplex        <= 1'b0;
         rx_frame_cnt         <= '0;
         rx_error_cnt         <= '0;
      end else begin
         state      <= state_n;
         spd_meta   <= phy_speed_status;
         spd        <= spd_meta;
         spd_d      <= spd;
         dv_prev    <= dv;
         nib_phase  <= nib_phase_n;
         if (dv && !gig && !nib_phase) nib_low <= rxd_rise;
         hold_valid <= hold_valid_n;
         hold_data  <= hold_data_n;
         frame_bad  <= frame_bad_n;
         fc_prev    <= fc_cond;

         rx_axis_rgmii_tvalid <= emit;
         rx_axis_rgmii_tlast  <= emit & emit_last;
         rx_axis_rgmii_tuser  <= emit & emit_user;
         if (emit) rx_axis_rgmii_tdata <= hold_data;

         if (!dv && !er) begin
            inband_link_status  <= rxd_rise[0];
            inband_speed_status <= rxd_rise[2:1];
            inband_duplex       <= rxd_rise[3];
         end

         rx_frame_cnt <= frame_sum[CNT_WIDTH] ? '1 : frame_sum[CNT_WIDTH-1:0];
         rx_error_cnt <= err_sum[CNT_WIDTH]   ? '1 : err_sum[CNT_WIDTH-1:0];
      end
   end

endmodule

// File: doc/rgmii_rx.md
Name: rgmii_rx

Overview:
RGMII receive decoder with 10/100/1000 Mbps rate adaptation. It is the receive-side counterpart of the RGMII transmit path. It takes the rise and fall samples of RXD/RX_CTL from external IDDR primitives in the PHY receive-clock domain and rebuilds bytes. It delivers frames on an AXIS master with tlast/tuser, decodes RGMII in-band link status, and counts frames and errors.

Parameters:
STRIP_PREAMBLE, 0, 1 = drop preamble bytes (0x55) and the SFD (0xD5) before output; 0 = pass every byte.
CNT_WIDTH, 16, width of the frame and error counters.

Ports:
clk_rx  in  1  RGMII RXC after the global buffer (125 / 25 / 2.5 MHz).
reset  in  1  synchronous, active-high.
rxd_rise  in  4  IDDR rising-edge sample of RXD.
rxd_fall  in  4  IDDR falling-edge sample of RXD.
rx_ctl_rise  in  1  IDDR rising-edge sample of RX_CTL (RX_DV).
rx_ctl_fall  in  1  IDDR falling-edge sample of RX_CTL (RX_DV xor RX_ER).
phy_speed_status  in  2  10 Mbps (0), 100 Mbps (1), 1000 Mbps (2); asynchronous, quasi-static.
rx_axis_rgmii_tdata  out  8  received byte.
rx_axis_rgmii_tvalid  out  1  byte valid.
rx_axis_rgmii_tlast  out  1  last byte of frame.
rx_axis_rgmii_tuser  out  1  frame bad; meaningful only when tlast=1.
inband_link_status  out  1  up (1), down (0).
inband_speed_status  out  2  same encoding as phy_speed_status.
inband_duplex  out  1  full (1).
rx_frame_cnt  out  CNT_WIDTH  count of frames emitted with tlast.
rx_error_cnt  out  CNT_WIDTH  count of bad, dropped or false-carrier events.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; hold register empty; counters 0.
- Clock and reset: single clock clk_rx; synchronous active-high reset.
- Speed input: phy_speed_status is synchronized with 2 FFs internally; the synchronized value is "spd". Decoded signals: dv = rx_ctl_rise; er = rx_ctl_rise ^ rx_ctl_fall.
- No backpressure: there is no tready. The downstream block must accept every beat.
- Byte assembly, 1000 Mbps (spd[1]=1): each cycle with dv=1 yields the byte {rxd_fall, rxd_rise}.
- Byte assembly, 10/100 Mbps: one nibble per cycle from rxd_rise, and rxd_fall is ignored. The first nibble after dv rises is the low nibble. A nibble_phase bit toggles each dv cycle and is cleared when dv=0. A byte completes on the high nibble.
- One-byte hold register, used to generate tlast:
  - A new byte arrives while the hold register is full: output the held byte with tvalid=1, tlast=0, then load the new byte.
  - dv=0 is sampled while the hold register is full: output the held byte with tlast=1 and empty the hold register.
  - All outputs are registered. tvalid is a single-cycle pulse per byte.
  - Latency: a byte completed at edge k appears at edge k+1 when the next byte follows directly. The last byte appears at the edge after the first dv=0 sample.
- Frame-bad flag, accumulated per frame and reported as tuser on the tlast beat. It is set by any of:
  - er=1 while dv=1;
  - an odd nibble count at frame end (10/100; the dangling nibble is discarded);
  - spd changes while dv=1. In that case the frame ends immediately: the held byte, if any, goes out with tlast=1 and tuser=1. The FSM then enters DROP until dv=0.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE -> DATA on dv=1 when STRIP_PREAMBLE=0.
  - IDLE -> PREAMBLE on dv=1 when STRIP_PREAMBLE=1.
  - PREAMBLE: byte 0x55 stays in PREAMBLE and is discarded.
  - PREAMBLE: byte 0xD5 -> DATA, and the SFD is discarded.
  - PREAMBLE: any other byte, er=1, or dv=0 -> DROP (or IDLE if dv=0), with rx_error_cnt+1 and no output.
  - DATA -> IDLE on dv=0, after emitting tlast as above.
  - DROP -> IDLE on dv=0.
- A frame that ends with the hold register empty produces no tlast beat. If the frame-bad flag is set, it counts as one error; otherwise it is ignored.
- In-band status: updated only on cycles where dv=0 and er=0, from rxd_rise:
  - bit0 -> inband_link_status;
  - bits[2:1] -> inband_speed_status;
  - bit3 -> inband_duplex.
  - These outputs hold their value otherwise.
- False carrier: dv=0, er=1 and rxd_rise=4'hE increments rx_error_cnt once per event (rising edge of the condition).
- Counters:
  - rx_frame_cnt increments on every tlast beat.
  - rx_error_cnt increments on every tlast beat with tuser=1, every dropped frame, and every false carrier.
  - Both counters saturate at all-ones.
- Reset mid-frame: everything clears the same cycle. After reset is released, a dv that is already high is treated as DROP until dv=0, so no partial frame is emitted.

Test Plan:
1. 1000 Mbps, STRIP_PREAMBLE=0, frame bytes 0x11,0x22,0x33 with no er -> three beats 0x11,0x22,0x33; tlast only on 0x33; tuser=0; rx_frame_cnt=1.
2. 100 Mbps, nibbles 1,2,3,4 on rxd_rise -> beats 0x21,0x43, tlast on 0x43. Then 10 Mbps with 5 nibbles -> 2 beats, tuser=1 on the last beat, rx_error_cnt=1.
3. STRIP_PREAMBLE=1, 1000 Mbps, 7x0x55, 0xD5, 0xAA, 0xBB -> only 0xAA,0xBB emitted. Preamble 0x55,0x12 -> no output, rx_error_cnt+1, FSM back to IDLE when dv=0.
4. er=1 on the second byte of a 4-byte frame -> all 4 beats delivered, tuser=1 on the 4th; rx_frame_cnt+1 and rx_error_cnt+1.
5. dv=0, er=0, rxd_rise=4'b1101 -> link=1, speed=2, duplex=1. A false carrier (ctl_fall=1, rxd=0xE) for 3 cycles -> rx_error_cnt+1 exactly once; in-band outputs unchanged.
6. Reset asserted on the 3rd byte of a frame with dv held high -> outputs 0 next edge; no beats until dv drops and a new frame starts; a speed change mid-frame -> held byte emitted with tlast=1, tuser=1.
